alu_sequencer: RTL and testbench
================================

# alu_sequencer

Fetch/decode/execute controller for the 12-bit microcontroller. Owns the program counter, instruction register, accumulator and status register, and sequences the 8-bit combinational ALU. It fetches 12-bit instructions from program memory, supplies ALU operands from the accumulator and data memory or an immediate, and writes the ALU result back to the accumulator or data memory. It also handles conditional jumps and halt.

## Interface
- PC_W, 8, program-counter / program-memory address width
- DA_W, 6, data-memory address width (equals the instruction address field)
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  pulse: leave IDLE/HALTED and begin fetching at current pc
- halted  out  1  high in HALTED state
- imem_addr  out  PC_W  program-memory address (registered pc)
- imem_data  in  12  instruction; valid the cycle after imem_addr
- dmem_addr  out  DA_W  data-memory address
- dmem_rdata  in  8  read data; valid the cycle after dmem_addr
- dmem_we  out  1  write strobe, one cycle
- dmem_wdata  out  8  write data
- alu_en  out  1  ALU Enable
- alu_op1  out  8  ALU Operand1 (always acc)
- alu_op2  out  8  ALU Operand2 (dmem_rdata or zero-extended immediate)
- alu_mode  out  4  ALU Mode
- alu_cflags  out  4  current status register to ALU
- alu_result  in  8  ALU Result
- alu_flags  in  4  ALU Flags: [0] V, [1] N, [2] C, [3] unused
- acc_out  out  8  accumulator, for debug
- sr_out  out  4  status register {Z,C,N,V} = [3:0]

## Operation
- Instruction types (ir[11:10]):
  - 00 = control. ir[9:8]: 00 = NOP, 01 = HALT, others = NOP.
  - 01 = jump. Condition ir[9:8]: 00 always, 01 Z, 10 C, 11 N. Target = ir[7:0].
  - 10 = M-type. Mode = ir[9:6], operand2 = mem[ir[5:0]].
  - 11 = I-type. Mode = ir[9:6], operand2 = {2'b00, ir[5:0]}.
- Write-back, M-type mode 0010: mem[addr] <= alu_result. Acc and sr are unchanged.
- Write-back, I-type mode 0010: no write at all; behaves as NOP.
- Write-back, all other modes: acc <= alu_result.
- Status update (only on an acc write):
  - Z <= (alu_result == 0); sequencer computes this, ignoring alu_flags[3].
  - Modes 0000, 0001, 1000, 1001, 1111: V, N, C <= alu_flags[0], [1], [2].
  - Mode 0111: V, N <= alu_flags[0], [1]; C is held.
  - Other modes: V, N, C are held.
- States:
  - IDLE: wait for start, then go to FETCH.
  - FETCH: imem_addr = pc, then go to DECODE.
  - DECODE: ir <= imem_data; pc <= pc+1; dmem_addr = imem_data[5:0]; go to EXEC.
  - EXEC: alu_en = 1 for M- and I-type only. Perform write-back or jump. Go to HALTED on HALT, otherwise FETCH.
  - HALTED: wait for start, then go to FETCH.
- Jump taken: pc <= target in EXEC, overriding the increment. Not taken: pc stays at pc+1.
- pc wraps from 2^PC_W−1 to 0; no trap.
- start is ignored outside IDLE/HALTED.

## Timing
- Reset values: pc = 0, ir = 0, acc = 0, sr = 0, state = IDLE.
- Outputs under reset: all outputs 0 (halted = 0, dmem_we = 0, alu_en = 0).
- Each instruction takes exactly 3 cycles (FETCH, DECODE, EXEC), with no overlap.
- The first FETCH is the cycle after start is sampled high.
- alu_en, alu_op*, alu_mode, dmem_we and dmem_wdata (= alu_result) are combinational from state and ir, and asserted only in EXEC.
- acc, sr and pc update on the clock edge that ends EXEC.
- Data memory reads: dmem_addr is driven in DECODE and held through EXEC, so dmem_rdata is valid in EXEC.
- Reset asserted at any point, including mid-EXEC: dmem_we and alu_en drop immediately (asynchronously), and no register update completes.

## Structure
- Package ucontroller_pkg holds:
  - instruction-type constants,
  - 4-bit ALU mode constants (ADD 0000 … CMPL 1111),
  - jump-condition codes,
  - state enum,
  - sr bit indices.
- Optional combinational sub-module alu_seq_decode: ir → {type, mode, addr/imm, cond, acc_we, mem_we, flag-update mask}. The FSM and registers stay in alu_sequencer.

## Test plan
- Immediate load and add: after reset, pulse start. Program: 0xCC5 (I-type mode 0011, imm 5), then 0xC03 (I-type ADD 3), then 0x100 (HALT).
  - Required: acc = 0x08, sr = 0000.
  - halted rises exactly 9 cycles after the first FETCH.
- Carry and zero: preload mem[1] = 0xFF. Program: 0x8C1 (load mem[1]), then 0xE00 (INC).
  - Required: acc = 0x00, sr.Z = 1, sr.C = 1.
- Store: acc = 0x5A, run 0x885.
  - Required: dmem_we high for exactly one cycle in EXEC, with addr 5 and data 0x5A.
  - acc and sr unchanged.
- Conditional jump: 0x510 (JZ 0x10).
  - Z = 1: next imem_addr = 0x10.
  - Z = 0: next imem_addr = pc+1.
- PC wrap: 0x4FF jumps to 0xFF, which holds NOP 0x000.
  - Required: the following fetch uses imem_addr = 0x00.
- Reset mid-operation: assert rst during EXEC of 0x885.
  - Required: dmem_we = 0 in the same cycle, no memory write, state IDLE, pc = 0, acc = 0.
  - After a new start pulse, fetch resumes at address 0.

Source files
------------

// File: rtl/ucontroller_pkg.sv
// Shared types and constants for the 12-bit microcontroller sequencer.
package ucontroller_pkg;

   localparam logic [1:0] T_CTRL = 2'b00;
   localparam logic [1:0] T_JUMP = 2'b01;
   localparam logic [1:0] T_MEM  = 2'b10;
   localparam logic [1:0] T_IMM  = 2'b11;

   localparam logic [1:0] CTL_HALT = 2'b01;

   localparam logic [3:0] M_ADD  = 4'b0000;
   localparam logic [3:0] M_SUB  = 4'b0001;
   localparam logic [3:0] M_STA  = 4'b0010;
   localparam logic [3:0] M_LDA  = 4'b0011;
   localparam logic [3:0] M_AND  = 4'b0100;
   localparam logic [3:0] M_OR   = 4'b0101;
   localparam logic [3:0] M_XOR  = 4'b0110;
   localparam logic [3:0] M_SHL  = 4'b0111;
   localparam logic [3:0] M_INC  = 4'b1000;
   localparam logic [3:0] M_DEC  = 4'b1001;
   localparam logic [3:0] M_CMPL = 4'b1111;

   localparam logic [1:0] C_ALW = 2'b00;
   localparam logic [1:0] C_Z   = 2'b01;
   localparam logic [1:0] C_C   = 2'b10;
   localparam logic [1:0] C_N   = 2'b11;

   localparam int SR_V = 0;
   localparam int SR_N = 1;
   localparam int SR_C = 2;
   localparam int SR_Z = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_HALTED
   } state_t;

   // flag_mask is aligned with sr[2:0] = {C,N,V}
   typedef struct packed {
      logic [1:0] typ;
      logic [3:0] mode;
      logic [5:0] addr;
      logic [7:0] imm;
      logic [1:0] cond;
      logic [7:0] target;
      logic       jump;
      logic       halt;
      logic       alu_use;
      logic       acc_we;
      logic       mem_we;
      logic [2:0] flag_mask;
   } dec_t;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational instruction decode: ir to control bundle.
module alu_seq_decode
   import ucontroller_pkg::*;
(
   input  logic [11:0] ir,
   output dec_t        dec
);

   always_comb begin
      dec        = '0;
      dec.typ    = ir[11:10];
      dec.mode   = ir[9:6];
      dec.addr   = ir[5:0];
      dec.imm    = {2'b00, ir[5:0]};
      dec.cond   = ir[9:8];
      dec.target = ir[7:0];
      unique case (ir[11:10])
         T_CTRL: dec.halt = (ir[9:8] == CTL_HALT);
         T_JUMP: dec.jump = 1'b1;
         T_MEM: begin
            dec.alu_use = 1'b1;
            dec.mem_we  = (ir[9:6] == M_STA);
            dec.acc_we  = (ir[9:6] != M_STA);
         end
         T_IMM: begin
            dec.alu_use = 1'b1;
            dec.acc_we  = (ir[9:6] != M_STA);
         end
         default: ;
      endcase
      if (dec.acc_we) begin
         unique case (ir[9:6])
            M_ADD, M_SUB, M_INC, M_DEC, M_CMPL:
               dec.flag_mask = 3'b111;
            M_SHL:
               dec.flag_mask = 3'b011;
            default:
               dec.flag_mask = 3'b000;
         endcase
      end
   end

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute controller: pc, ir, acc, sr and ALU sequencing.
module alu_sequencer
   import ucontroller_pkg::*;
#(
   parameter int PC_W = 8,
   parameter int DA_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic            halted,
   output logic [PC_W-1:0] imem_addr,
   input  logic [11:0]     imem_data,
   output logic [DA_W-1:0] dmem_addr,
   input  logic [7:0]      dmem_rdata,
   output logic            dmem_we,
   output logic [7:0]      dmem_wdata,
   output logic            alu_en,
   output logic [7:0]      alu_op1,
   output logic [7:0]      alu_op2,
   output logic [3:0]      alu_mode,
   output logic [3:0]      alu_cflags,
   input  logic [7:0]      alu_result,
   input  logic [3:0]      alu_flags,
   output logic [7:0]      acc_out,
   output logic [3:0]      sr_out
);

   state_t          state, nstate;
   logic [PC_W-1:0] pc;
   logic [11:0]     ir;
   logic [7:0]      acc;
   logic [3:0]      sr;
   dec_t            dec;
   logic            exec;
   logic            taken;

   alu_seq_decode u_dec (
      .ir  (ir),
      .dec (dec)
   );

   assign exec = (state == S_EXEC);

   always_comb begin
      taken = 1'b0;
      unique case (dec.cond)
         C_ALW: taken = 1'b1;
         C_Z:   taken = sr[SR_Z];
         C_C:   taken = sr[SR_C];
         C_N:   taken = sr[SR_N];
         default: taken = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= nstate;
   end

   always_comb begin
      nstate = state;
      unique case (state)
         S_IDLE, S_HALTED:
            if (start) nstate = S_FETCH;
         S_FETCH:  nstate = S_DECODE;
         S_DECODE: nstate = S_EXEC;
         S_EXEC:
            nstate = dec.halt ? S_HALTED : S_FETCH;
         default:  nstate = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc  <= '0;
         ir  <= '0;
         acc <= '0;
         sr  <= '0;
      end else begin
         if (state == S_DECODE) begin
            ir <= imem_data;
            pc <= pc + 1'b1;
         end
         if (exec) begin
            if (dec.jump && taken)
               pc <= PC_W'(dec.target);
            if (dec.acc_we) begin
               acc      <= alu_result;
               sr[SR_Z] <= (alu_result == 8'h00);
               sr[2:0]  <= (alu_flags[2:0] & dec.flag_mask)
                         | (sr[2:0] & ~dec.flag_mask);
            end
         end
      end
   end

   always_comb begin
      halted     = (state == S_HALTED);
      imem_addr  = pc;
      dmem_addr  = (state == S_DECODE) ? DA_W'(imem_data[5:0])
                                       : DA_W'(dec.addr);
      alu_en     = exec && dec.alu_use;
      alu_op1    = exec ? acc : 8'h00;
      alu_op2    = 8'h00;
      if (exec)
         alu_op2 = (dec.typ == T_MEM) ? dmem_rdata : dec.imm;
      alu_mode   = exec ? dec.mode : 4'h0;
      dmem_we    = exec && dec.mem_we;
      dmem_wdata = dmem_we ? alu_result : 8'h00;
      alu_cflags = sr;
      acc_out    = acc;
      sr_out     = sr;
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with memory and ALU models.
module tb_alu_sequencer;
   import ucontroller_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       halted;
   logic [7:0] imem_addr;
   logic [11:0] imem_data;
   logic [5:0] dmem_addr;
   logic [7:0] dmem_rdata;
   logic       dmem_we;
   logic [7:0] dmem_wdata;
   logic       alu_en;
   logic [7:0] alu_op1, alu_op2;
   logic [3:0] alu_mode, alu_cflags;
   logic [7:0] alu_result;
   logic [3:0] alu_flags;
   logic [7:0] acc_out;
   logic [3:0] sr_out;

   logic [11:0] imem [0:255];
   logic [7:0]  dmem [0:63];

   int n_cmp = 0;
   int n_bad = 0;
   int addr_log [0:63];
   int halt_cyc;
   int we_cnt;
   logic [5:0] we_addr;
   logic [7:0] we_data;

   alu_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .halted     (halted),
      .imem_addr  (imem_addr),
      .imem_data  (imem_data),
      .dmem_addr  (dmem_addr),
      .dmem_rdata (dmem_rdata),
      .dmem_we    (dmem_we),
      .dmem_wdata (dmem_wdata),
      .alu_en     (alu_en),
      .alu_op1    (alu_op1),
      .alu_op2    (alu_op2),
      .alu_mode   (alu_mode),
      .alu_cflags (alu_cflags),
      .alu_result (alu_result),
      .alu_flags  (alu_flags),
      .acc_out    (acc_out),
      .sr_out     (sr_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      imem_data  <= imem[imem_addr];
      dmem_rdata <= dmem[dmem_addr];
      if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
   end

   // ALU model; pass-through modes return all-ones flags to expose masking
   always_comb begin
      logic c;
      c = 1'b0;
      alu_result = alu_op1;
      alu_flags  = 4'b1111;
      unique case (alu_mode)
         M_ADD: begin
            {c, alu_result} = {1'b0, alu_op1} + {1'b0, alu_op2};
            alu_flags = {1'b1, c, alu_result[7],
               (alu_op1[7] == alu_op2[7]) &&
               (alu_result[7] != alu_op1[7])};
         end
         M_INC: begin
            {c, alu_result} = {1'b0, alu_op1} + 9'd1;
            alu_flags = {1'b1, c, alu_result[7],
               alu_op1 == 8'h7F};
         end
         M_LDA: alu_result = alu_op2;
         default: alu_result = alu_op1;
      endcase
   end

   always @(negedge clk) begin
      if (dmem_we) begin
         we_cnt  = we_cnt + 1;
         we_addr = dmem_addr;
         we_data = dmem_wdata;
      end
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic clr_imem();
      for (int i = 0; i < 256; i++) imem[i] = 12'h100;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // cycle 1 is the first FETCH; call right after pulse_start
   task automatic run(input int n);
      halt_cyc = -1;
      for (int c = 1; c <= n; c++) begin
         if (c > 1) @(negedge clk);
         addr_log[c] = int'(imem_addr);
         if (halted && halt_cyc < 0) halt_cyc = c;
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) dmem[i] = 8'h00;
      clr_imem();
      we_cnt = 0;
      do_reset();

      chk("rst_halted", halted, 0);
      chk("rst_we", dmem_we, 0);
      chk("rst_alu_en", alu_en, 0);
      chk("rst_iaddr", imem_addr, 0);
      chk("rst_acc", acc_out, 0);
      chk("rst_sr", sr_out, 0);
      chk("rst_daddr", dmem_addr, 0);

      imem[0] = 12'hCC5;
      imem[1] = 12'hC03;
      imem[2] = 12'h100;
      pulse_start();
      run(14);
      chk("t1_acc", acc_out, 8'h08);
      chk("t1_sr", sr_out, 4'b0000);
      chk("t1_halt_lat", halt_cyc - 1, 9);
      chk("t1_fetch2", addr_log[4], 1);

      do_reset();
      clr_imem();
      dmem[1] = 8'hFF;
      dmem[2] = 8'h5A;
      imem[0] = 12'h8C1;
      imem[1] = 12'hE00;
      imem[2] = 12'h100;
      imem[3] = 12'h8C2;
      imem[4] = 12'h885;
      imem[5] = 12'h100;
      pulse_start();
      run(14);
      chk("t2_halt", halt_cyc, 10);
      chk("t2_acc", acc_out, 8'h00);
      chk("t2_sr", sr_out, 4'b1100);

      we_cnt = 0;
      pulse_start();
      chk("t3_resume", imem_addr, 3);
      run(14);
      chk("t3_halt", halt_cyc, 10);
      chk("t3_we_cnt", we_cnt, 1);
      chk("t3_we_addr", we_addr, 5);
      chk("t3_we_data", we_data, 8'h5A);
      chk("t3_mem5", dmem[5], 8'h5A);
      chk("t3_acc", acc_out, 8'h5A);
      chk("t3_sr", sr_out, 4'b0100);

      do_reset();
      clr_imem();
      imem[0] = 12'hCC0;
      imem[1] = 12'h510;
      pulse_start();
      run(14);
      chk("t4z_jaddr", addr_log[4], 1);
      chk("t4z_taken", addr_log[7], 8'h10);
      chk("t4z_pc", imem_addr, 8'h11);

      do_reset();
      clr_imem();
      imem[0] = 12'hCC1;
      imem[1] = 12'h510;
      pulse_start();
      run(14);
      chk("t4nz_fall", addr_log[7], 2);
      chk("t4nz_sr", sr_out, 4'b0000);

      do_reset();
      clr_imem();
      imem[0]     = 12'h4FF;
      imem[8'hFF] = 12'h000;
      pulse_start();
      run(9);
      chk("t5_ff", addr_log[4], 8'hFF);
      chk("t5_wrap", addr_log[7], 0);

      do_reset();
      clr_imem();
      dmem[5] = 8'h00;
      imem[0] = 12'h8C2;
      imem[1] = 12'h885;
      imem[2] = 12'h100;
      pulse_start();
      repeat (5) @(negedge clk);
      chk("t6_we_pre", dmem_we, 1);
      #1 rst = 1'b1;
      #1;
      chk("t6_we_rst", dmem_we, 0);
      chk("t6_alu_rst", alu_en, 0);
      chk("t6_pc_rst", imem_addr, 0);
      chk("t6_acc_rst", acc_out, 0);
      @(negedge clk);
      rst = 1'b0;
      chk("t6_nowrite", dmem[5], 8'h00);
      repeat (3) @(negedge clk);
      chk("t6_idle_pc", imem_addr, 0);
      chk("t6_idle_halt", halted, 0);
      pulse_start();
      run(14);
      chk("t6_refetch", addr_log[1], 0);
      chk("t6_halt", halt_cyc, 10);
      chk("t6_mem5", dmem[5], 8'h5A);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
